// File: rtl/serial_adder_sequencer.sv
// -----------------------------------------------------------------------------
// serial_adder_sequencer
//
// Adds or subtracts two WIDTH-bit operands one bit per clock, LSB first, by
// reusing a single 1-bit full adder cell. Each operation takes WIDTH cycles
// in RUN and is reported by a one-cycle DONE state. Back-to-back operations
// are accepted directly from DONE.
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   reset     synchronous, active-high reset; dominates every other input
//   start     request a new operation; sampled only in IDLE or DONE
//   sub       0 = a + b, 1 = a - b (two's complement); sampled with start
//   a, b      WIDTH-bit operands; sampled with start
//   busy      high while the operation is running (WIDTH cycles)
//   done      one-cycle completion pulse
//   result    sum/difference, updated only when an operation completes
//   carryout  carry out of the MSB (subtract: 1 = no borrow)
//   overflow  signed overflow (carry into MSB xor carry out of MSB)
//   zero      result == 0
// -----------------------------------------------------------------------------

// Single-bit full adder cell, kept as its own module so the sequencer reuses
// one physical adder bit rather than inferring a WIDTH-bit adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic carryin,
    output logic sum,
    output logic carryout
);
    assign sum      = a ^ b ^ carryin;
    assign carryout = (a & b) | (carryin & (a ^ b));
endmodule

module serial_adder_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT    = CW'(WIDTH - 1);
    localparam logic [CW-1:0] MSB_CIN_BIT = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nxt;
    logic   load;

    logic [WIDTH-1:0] opa, opb, shr;
    logic [CW-1:0]    count;
    logic             carry;
    logic             cmsb_in;

    logic             fa_sum, fa_co;
    logic [WIDTH-1:0] sum_word;

    full_adder_cell u_fa (
        .a        (opa[0]),
        .b        (opb[0]),
        .carryin  (carry),
        .sum      (fa_sum),
        .carryout (fa_co)
    );

    // The shift register contents after this cycle's bit is shifted in; on
    // the last bit this is the complete result.
    assign sum_word = {fa_sum, shr[WIDTH-1:1]};

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // NOTE: every output of this block gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN: begin
                if (count == LAST_BIT) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values of its inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opa      <= '0;
            opb      <= '0;
            shr      <= '0;
            count    <= '0;
            carry    <= 1'b0;
            cmsb_in  <= 1'b0;
            result   <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b1;
        end else if (load) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub;
            count <= '0;
        end else if (state == RUN) begin
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            shr   <= sum_word;
            carry <= fa_co;
            count <= count + CW'(1);
            // Carry produced by bit WIDTH-2 is the carry into the MSB.
            if (count == MSB_CIN_BIT) begin
                cmsb_in <= fa_co;
            end
            if (count == LAST_BIT) begin
                result   <= sum_word;
                carryout <= fa_co;
                overflow <= cmsb_in ^ fa_co;
                zero     <= (sum_word == '0);
            end
        end
    end

endmodule
